// File: rtl/mac_array_pkg.sv
// Shared parameters, lane/product typedefs and the output reduction for mac_array.
// Optional feature: MAC_ARRAY_SATURATE_EN selects a saturating output reduction.
// When it is not defined, the output keeps the low 16 bits (wrap).
package mac_array_pkg;
  localparam int LANES  = 8;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 2 * DATA_W;
  // The adder tree is wide enough for 8 full products with no overflow.
  // Flooring by FRAC_W then keeps the low ACC_W bits.
  localparam int SUM_W  = ACC_W + FRAC_W;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [ACC_W:0]    pre_t;   // acc + bias, no overflow

  // Reduce acc+bias to the 16-bit Q8.8 output.
  function automatic data_t reduce_out(input pre_t v);
`ifdef MAC_ARRAY_SATURATE_EN
    if (v > pre_t'(32767))
      return data_t'(16'h7fff);
    else if (v < pre_t'(-32768))
      return data_t'(16'h8000);
    else
      return data_t'(v);
`else
    return data_t'(v);
`endif
  endfunction
endpackage

// File: rtl/mac_array_lane.sv
// mac_lane: one signed 16x16 multiplier lane.
// The operands are registered, and then the full 32-bit product is registered.
module mac_lane
  import mac_array_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_w,
  output logic [PROD_W-1:0] o_p
);
  data_t r_x, r_w;
  prod_t r_p;

  // Operand capture, then the product register (stage 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_w <= '0;
      r_p <= '0;
    end else begin
      r_x <= data_t'(i_x);
      r_w <= data_t'(i_w);
      r_p <= prod_t'(r_x) * prod_t'(r_w);
    end
  end

  assign o_p = r_p;
endmodule

// File: rtl/mac_array.sv
// mac_array: 8-lane Q8.8 dot-product MAC with accumulator and registered output.
// Timing: inputs and en are sampled at edge N. The products are registered at N+1.
// The accumulator updates at N+2, and dot_product updates at N+3 when read_en=1.
// Optional feature: MAC_ARRAY_SATURATE_EN (see mac_array_pkg) makes the output saturate.
module mac_array
  import mac_array_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] DMA_channel_0,
  input  logic [63:0] DMA_channel_1,
  input  logic [63:0] DMA_channel_2,
  input  logic [63:0] DMA_channel_3,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] bias,
  input  logic        read_en,
  output logic [15:0] dot_product
);
  logic [LANES-1:0][DATA_W-1:0] w_x, w_w;
  logic [LANES-1:0][PROD_W-1:0] w_p;
  sum_t  w_sum;
  pre_t  w_pre;
  logic [1:0] r_vld_pipe;   // [0]: operands captured, [1]: products valid
  acc_t  r_acc;
  data_t r_dot;

  assign w_x = {DMA_channel_1, DMA_channel_0};
  assign w_w = {DMA_channel_3, DMA_channel_2};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_x   (w_x[g]),
      .i_w   (w_w[g]),
      .o_p   (w_p[g])
    );
  end

  // Adder tree: a full-precision sum of the lane products.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_sum = w_sum + sum_t'($signed(w_p[i]));
  end

  // Valid shift register. clr drops everything in flight, including this cycle's en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_vld_pipe <= '0;
    else if (clr) r_vld_pipe <= '0;
    else          r_vld_pipe <= {r_vld_pipe[0], en};
  end

  // Accumulator: adds the floored (>>> FRAC_W) product sum and wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_acc <= '0;
    else if (clr)           r_acc <= '0;
    else if (r_vld_pipe[1]) r_acc <= acc_t'(r_acc + acc_t'(w_sum >>> FRAC_W));
  end

  assign w_pre = pre_t'(r_acc) + pre_t'($signed(bias));

  // Output register: loads the reduced acc+bias on read_en. clr does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_dot <= '0;
    else if (read_en) r_dot <= reduce_out(w_pre);
  end

  assign dot_product = r_dot;
endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array. It uses directed steps plus a randomized run.
// The expected output comes from a cycle-history model of the accumulator.
module tb_mac_array;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] DMA_channel_0 = '0, DMA_channel_1 = '0, DMA_channel_2 = '0, DMA_channel_3 = '0;
  logic        en = 1'b0, clr = 1'b0, read_en = 1'b0;
  logic [15:0] bias = '0;
  logic [15:0] dot_product;

  mac_array dut (
    .clk(clk), .rst_n(rst_n),
    .DMA_channel_0(DMA_channel_0), .DMA_channel_1(DMA_channel_1),
    .DMA_channel_2(DMA_channel_2), .DMA_channel_3(DMA_channel_3),
    .en(en), .clr(clr), .bias(bias), .read_en(read_en),
    .dot_product(dot_product)
  );

  always #5 clk = ~clk;

  // Stimulus for the next step.
  logic [15:0] tx [8];
  logic [15:0] tw [8];
  logic        t_rst = 1'b0, t_en = 1'b0, t_clr = 1'b0, t_rd = 1'b0;
  logic [15:0] t_bias = '0;

  // History of each edge: was en accepted, was there a clear, and the lane contribution.
  localparam int MAXC = 1024;
  bit     en_h  [MAXC];
  bit     clr_h [MAXC];
  longint ctb_h [MAXC];
  int     cyc = 0;
  logic [15:0] exp_dot = '0;
  int nchk = 0, npass = 0;

  function automatic longint s32(input longint v);
    longint r;
    r = v & 64'h0000_0000_FFFF_FFFF;
    if (r >= 64'sh8000_0000) r = r - 64'sh1_0000_0000;
    return r;
  endfunction

  // Contribution of one set of lanes: floor(sum(x*w) / 2^FRAC_W), kept to 32 bits.
  function automatic longint lane_contrib();
    longint s = 0;
    for (int i = 0; i < 8; i++)
      s += longint'($signed(tx[i])) * longint'($signed(tw[i]));
    return s32(s >>> 8);
  endfunction

  // Accumulator value after edge k. It is the sum of every en accepted after the
  // latest clear or reset whose 2-edge latency has elapsed by k.
  function automatic longint acc_after(input int k);
    int m = 0;
    longint a = 0;
    for (int j = 0; j <= k; j++) if (clr_h[j]) m = j;
    for (int j = m + 1; j <= k - 2; j++) if (en_h[j]) a += ctb_h[j];
    return s32(a);
  endfunction

  function automatic logic [15:0] reduce(input longint v);
`ifdef MAC_ARRAY_SATURATE_EN
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: dot_product=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
  endtask

  task automatic set_lanes(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < 8; i++) begin tx[i] = x; tw[i] = w; end
  endtask

  // One clock step. Drive at the negedge, record the edge in the model, check #1 after the edge.
  task automatic step(input string tag);
    @(negedge clk);
    rst_n = t_rst; en = t_en; clr = t_clr; read_en = t_rd; bias = t_bias;
    DMA_channel_0 = {tx[3], tx[2], tx[1], tx[0]};
    DMA_channel_1 = {tx[7], tx[6], tx[5], tx[4]};
    DMA_channel_2 = {tw[3], tw[2], tw[1], tw[0]};
    DMA_channel_3 = {tw[7], tw[6], tw[5], tw[4]};
    @(posedge clk);
    cyc++;
    en_h[cyc]  = t_en && t_rst;
    clr_h[cyc] = t_clr || !t_rst;
    ctb_h[cyc] = lane_contrib();
    if (!t_rst)    exp_dot = 16'h0000;
    else if (t_rd) exp_dot = reduce(acc_after(cyc - 1) + longint'($signed(t_bias)));
    #1 chk(tag, dot_product, exp_dot);
  endtask

  task automatic idle(input string tag, input int n);
    t_en = 1'b0; t_clr = 1'b0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    set_lanes(16'h0000, 16'h0000);
    clr_h[0] = 1'b1;

    // Reset state.
    #2 chk("reset_async", dot_product, 16'h0000);
    t_rst = 1'b0; step("reset"); step("reset");
    t_rst = 1'b1; t_rd = 1'b1;

    // A single en with 1.0 * 2.0 across 8 lanes gives 0x1000 at edge N+3.
    set_lanes(16'h0100, 16'h0200);
    t_en = 1'b1; step("single_en_N");
    idle("latency", 3);
    chk("single_en_val", dot_product, 16'h1000);

    // en held for 2 cycles gives 0x2000. Then clr with bias 0x0080 gives 0x0080.
    t_clr = 1'b1; step("clr0"); t_clr = 1'b0;
    t_en = 1'b1; step("en2_a"); step("en2_b");
    idle("en2_drain", 3);
    chk("en2_val", dot_product, 16'h2000);
    t_bias = 16'h0080; t_clr = 1'b1; step("clr_bias");
    idle("after_clr", 1);
    chk("clr_bias_val", dot_product, 16'h0080);

    // read_en=0 holds the output while accumulating. read_en=1 shows the new value.
    t_rd = 1'b0; t_en = 1'b1; set_lanes(16'h0180, 16'hff40);
    step("hold_a"); step("hold_b"); step("hold_c");
    idle("hold_drain", 2);
    t_rd = 1'b1; step("read_again");

    // clr and en in the same cycle discard that cycle's lanes.
    t_bias = 16'h0123; set_lanes(16'h0400, 16'h0400);
    t_clr = 1'b1; t_en = 1'b1; step("clr_en_same");
    idle("clr_en_drain", 3);
    chk("clr_en_val", dot_product, 16'h0123);

    // Large positive accumulation (all lanes 0xAAAA).
    t_bias = 16'h0000; t_clr = 1'b1; step("clr_sat");
    set_lanes(16'hAAAA, 16'hAAAA); t_clr = 1'b0; t_en = 1'b1;
    for (int i = 0; i < 4; i++) step("sat_pos");
    idle("sat_pos_drain", 3);
`ifdef MAC_ARRAY_SATURATE_EN
    chk("sat_pos_val", dot_product, 16'h7fff);
`endif
    // Large negative accumulation (x=0xAAAA, w=1.0).
    t_clr = 1'b1; step("clr_neg");
    set_lanes(16'hAAAA, 16'h0100); t_clr = 1'b0; t_en = 1'b1;
    for (int i = 0; i < 4; i++) step("sat_neg");
    idle("sat_neg_drain", 3);
`ifdef MAC_ARRAY_SATURATE_EN
    chk("sat_neg_val", dot_product, 16'h8000);
`endif

    // Randomized traffic, with an asynchronous reset partway through.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) begin
        tx[i] = 16'($urandom);
        tw[i] = 16'($urandom);
      end
      t_en   = ($urandom_range(0, 1) == 1);
      t_rd   = ($urandom_range(0, 9) < 7);
      t_clr  = ($urandom_range(0, 19) == 0);
      t_bias = 16'($urandom);
      step("random");
      if (n == 150) begin
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset_async", dot_product, 16'h0000);
        t_rst = 1'b0; step("midrun_reset");
        t_rst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: DMA_channel_0  input  64  activations x[0..3], lane i = bits [16i+15:16i].
REQ-004 SHALL have port: DMA_channel_1  input  64  activations x[4..7], same lane packing.
REQ-005 SHALL have port: DMA_channel_2  input  64  weights w[0..3], same lane packing.
REQ-006 SHALL have port: DMA_channel_3  input  64  weights w[4..7], same lane packing.
REQ-007 SHALL have port: en  input  1  accept current lanes into the pipeline.
REQ-008 SHALL have port: clr  input  1  synchronous clear of accumulator and pipeline.
REQ-009 SHALL have port: bias  input  16  signed Q8.8 bias added at output.
REQ-010 SHALL have port: read_en  input  1  update output register.
REQ-011 SHALL have port: dot_product  output  16  registered signed Q8.8 result.

Function
REQ-012 SHALL treat every lane, bias and dot_product as two's-complement Q8.8 (DATA_W=16, FRAC_W=8).
REQ-013 Stage 1 SHALL register 8 full 32-bit signed products p[i]=x[i]*w[i] and a valid bit equal to en.
REQ-014 Stage 2 SHALL, when stage-1 valid, add to the accumulator the sum of all p[i] arithmetically shifted right by FRAC_W (truncation toward minus infinity); the sum is ACC_W=32 bits signed.
REQ-015 The accumulator SHALL wrap modulo 2^32 on overflow.
REQ-016 Stage 3: when read_en=1, dot_product SHALL load acc+bias (bias sign-extended), reduced to 16 bits per REQ-022; when read_en=0 it holds.
REQ-017 Latency SHALL be: en sampled at edge N -> accumulator updated at edge N+2 -> visible on dot_product at edge N+3 (read_en=1).
REQ-018 en SHALL be accepted every cycle (no backpressure; throughput 8 MACs/cycle).
REQ-019 clr=1 SHALL zero the accumulator and both stage valid bits at the next edge; clr has priority over en and in-flight data; dot_product is not cleared but reloads bias on next read_en.
REQ-020 With en=0 the accumulator SHALL hold; pipeline data already in flight still commits.

Reset
REQ-021 rst_n=0 SHALL immediately force accumulator, product registers, valid bits and dot_product to 0, independent of clk.

Configuration
REQ-022 Macro MAC_ARRAY_SATURATE_EN: defined -> output reduction saturates acc+bias to [0x8000, 0x7FFF]; undefined -> output takes low 16 bits (wrap).

Structure
REQ-023 Package mac_array_pkg SHALL hold LANES=8, DATA_W=16, FRAC_W=8, ACC_W=32 and the lane/product data typedefs.
REQ-024 One sub-module mac_lane (registered signed 16x16 multiplier) SHALL be instantiated LANES times; adder tree, accumulator and output stage live in mac_array.

Verification
REQ-025 rst_n=0 mid-run -> dot_product=0x0000 immediately, accumulator 0 after release.
REQ-026 all x=0x0100, w=0x0200, bias=0, en one cycle, read_en=1 -> dot_product=0x1000 at edge N+3.
REQ-027 same lanes, en held 2 cycles -> 0x2000; then clr one cycle with bias=0x0080 -> dot_product=0x0080.
REQ-028 all lanes 0xAAAA, en and read_en held (SATURATE_EN) -> dot_product=0x7FFF; x=0xAAAA, w=0x0100 -> 0x8000.
REQ-029 read_en=0 while accumulating -> dot_product holds previous value; read_en=1 -> current acc+bias next edge.
REQ-030 clr and en asserted same cycle -> accumulator 0, that cycle's lanes discarded.
